// File: rtl/ro_meas_ctrl_if.sv
// rtl/ro_meas_ctrl_if.sv - pin-side signal bundle of the ring-oscillator measurement sequencer
interface ro_meas_ctrl_if #(
    parameter int GATE_W = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [GATE_W-1:0] gate_len;
    logic              cont_mode;
    logic              ro_in;
    logic              ro_en;
    logic              busy;
    logic              done;
    logic              valid;
    logic [CNT_W-1:0]  count;
    logic              ovf;

    modport master (
        output start, gate_len, cont_mode, ro_in,
        input  ro_en, busy, done, valid, count, ovf
    );

    modport slave (
        input  start, gate_len, cont_mode, ro_in,
        output ro_en, busy, done, valid, count, ovf
    );
endinterface

// File: rtl/ro_meas_ctrl.sv
// rtl/ro_meas_ctrl.sv - ring-oscillator settle/gate/count/publish sequencer
// Optional continuous re-measure: define RO_CONT_EN.
module ro_meas_ctrl #(
    parameter int CNT_W         = 16,
    parameter int GATE_W        = 16,
    parameter int SETTLE_CYCLES = 16
) (
    input logic          clk,
    input logic          rst,
    ro_meas_ctrl_if.slave bus
);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, PUBLISH} state_t;

    state_t            state_q;
    logic [2:0]        sync_q;
    logic [SET_W-1:0]  settle_cnt_q;
    logic [GATE_W-1:0] gate_cnt_q;
    logic [GATE_W-1:0] gate_len_q;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic              ro_en_q, busy_q, done_q, valid_q, ovf_q;
    logic [CNT_W-1:0]  count_q;
    logic [GATE_W-1:0] gate_len_eff;
    logic              ro_rise;

    // A sub-clk/2 oscillator is assumed; faster inputs alias in the synchronizer.
    assign ro_rise      = sync_q[1] & ~sync_q[2];
    assign gate_len_eff = (bus.gate_len == '0) ? GATE_W'(1) : bus.gate_len;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        ovf_acc_d  = ovf_acc_q;
        if (state_q == GATE && ro_rise) begin
            if (&edge_cnt_q) ovf_acc_d  = 1'b1;
            else             edge_cnt_d = edge_cnt_q + CNT_W'(1);
        end
    end

`ifndef RO_CONT_EN
    logic cont_mode_unused;
    assign cont_mode_unused = bus.cont_mode;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            settle_cnt_q <= '0;
            gate_cnt_q   <= '0;
            gate_len_q   <= '0;
            edge_cnt_q   <= '0;
            ovf_acc_q    <= 1'b0;
            ro_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], bus.ro_in};
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q      <= SETTLE;
                        gate_len_q   <= gate_len_eff;
                        valid_q      <= 1'b0;
                        ovf_q        <= 1'b0;
                        edge_cnt_q   <= '0;
                        ovf_acc_q    <= 1'b0;
                        settle_cnt_q <= '0;
                        busy_q       <= 1'b1;
                        ro_en_q      <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == SET_LAST) begin
                        state_q    <= GATE;
                        gate_cnt_q <= '0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SET_W'(1);
                    end
                end
                GATE: begin
                    edge_cnt_q <= edge_cnt_d;
                    ovf_acc_q  <= ovf_acc_d;
                    // Result is registered on the last gate edge so count is valid alongside done.
                    if (gate_cnt_q == gate_len_q - GATE_W'(1)) begin
                        state_q <= PUBLISH;
                        ro_en_q <= 1'b0;
                        done_q  <= 1'b1;
                        count_q <= edge_cnt_d;
                        ovf_q   <= ovf_acc_d;
                        valid_q <= 1'b1;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + GATE_W'(1);
                    end
                end
                PUBLISH: begin
`ifdef RO_CONT_EN
                    if (bus.cont_mode) begin
                        state_q      <= SETTLE;
                        gate_len_q   <= gate_len_eff;
                        edge_cnt_q   <= '0;
                        ovf_acc_q    <= 1'b0;
                        settle_cnt_q <= '0;
                        ro_en_q      <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
`else
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ro_en = ro_en_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.valid = valid_q;
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_ro_meas_ctrl.sv
// tb/tb_ro_meas_ctrl.sv - directed vector bench for ro_meas_ctrl
module tb_ro_meas_ctrl;
    localparam int S = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ro_meas_ctrl_if #(.GATE_W(16), .CNT_W(4)) bus ();

    ro_meas_ctrl #(.CNT_W(4), .GATE_W(16), .SETTLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int ro_period = 0;
    int ro_phase  = 0;

    // Square-wave oscillator model, period in clk cycles (<2 means held low).
    initial begin
        bus.ro_in = 1'b0;
        forever begin
            @(negedge clk);
            if (ro_period < 2) begin
                ro_phase  = 0;
                bus.ro_in = 1'b0;
            end else begin
                ro_phase  = (ro_phase + 1) % ro_period;
                bus.ro_in = (ro_phase < ro_period / 2);
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    typedef struct {
        int gate;
        int period;
        int lat;
        int cnt_lo;
        int cnt_hi;
        int ovf;
        int poke;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input string tag);
        int n, ro_hi, dones, lat, cnt_at_done;
        ro_period = v.period;
        @(negedge clk);
        bus.gate_len = 16'(v.gate);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("%s_busy_on_accept", tag), bus.busy, 1, 1);
        chk($sformatf("%s_valid_cleared", tag), bus.valid, 0, 0);
        bus.start = 1'b0;
        n = 0; ro_hi = 0; dones = 0; lat = -1; cnt_at_done = -1;
        while (n < v.lat + 40) begin
            if (bus.ro_en) ro_hi++;
            if (bus.done) begin
                dones++;
                if (lat < 0) begin
                    lat = n;
                    cnt_at_done = int'(bus.count);
                end
            end
            if (n == v.poke) begin
                bus.start    = 1'b1;
                bus.gate_len = 16'd5;
            end else if (n == v.poke + 1) begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("%s_done_latency", tag), lat, v.lat, v.lat);
        chk($sformatf("%s_ro_en_cycles", tag), ro_hi, v.lat, v.lat);
        chk($sformatf("%s_done_pulses", tag), dones, 1, 1);
        chk($sformatf("%s_count", tag), bus.count, v.cnt_lo, v.cnt_hi);
        chk($sformatf("%s_count_stable", tag), bus.count, cnt_at_done, cnt_at_done);
        chk($sformatf("%s_ovf", tag), bus.ovf, v.ovf, v.ovf);
        chk($sformatf("%s_valid", tag), bus.valid, 1, 1);
        chk($sformatf("%s_idle", tag), bus.busy, 0, 0);
    endtask

    initial begin
        int t[$];
        int busy_low;
        int n;
        vec_t fresh;

        //        gate period lat  lo  hi ovf poke
        vecs[0] = '{64,  8,  80,  8,  8, 0, -1};
        vecs[1] = '{256, 4,  272, 15, 15, 1, -1};
        vecs[2] = '{16,  4,  32,  4,  4, 0, -1};
        vecs[3] = '{0,   4,  17,  0,  1, 0, -1};
        vecs[4] = '{20,  10, 36,  2,  2, 0, -1};
        vecs[5] = '{40,  0,  56,  0,  0, 0, -1};
        vecs[6] = '{64,  8,  80,  8,  8, 0, 30};

        bus.start     = 1'b0;
        bus.gate_len  = '0;
        bus.cont_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.ro_en, bus.busy, bus.done, bus.valid, bus.count, bus.ovf}, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_reset", {bus.ro_en, bus.busy, bus.done, bus.valid}, 0, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Asynchronous reset in the middle of the gate window.
        ro_period = 4;
        @(negedge clk);
        bus.gate_len = 16'd64;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_gate_outputs", {bus.ro_en, bus.busy, bus.done, bus.valid, bus.count, bus.ovf}, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fresh = '{16, 4, 32, 4, 4, 0, -1};
        run_vec(fresh, "post_rst");

        // start held high: restart is accepted in the first IDLE cycle.
        ro_period = 0;
        @(negedge clk);
        bus.gate_len = 16'd4;
        bus.start    = 1'b1;
        busy_low = 0;
        n = 0;
        t.delete();
        while (n < 120 && t.size() < 2) begin
            @(posedge clk); #1;
            n++;
            if (bus.done) t.push_back(n);
            if (t.size() == 1 && !bus.busy) busy_low++;
        end
        bus.start = 1'b0;
        chk("held_start_dones", t.size(), 2, 2);
        if (t.size() == 2) chk("held_start_spacing", t[1] - t[0], S + 4 + 2, S + 4 + 2);
        chk("held_start_busy_gap", busy_low, 1, 1);
        n = 0;
        while (n < 60 && bus.busy) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_start_drain", bus.busy, 0, 0);

        // Continuous mode: cleared during the third measurement.
        @(negedge clk);
        bus.cont_mode = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_low = 0;
        n = 0;
        t.delete();
        while (n < 150) begin
            if (bus.done) t.push_back(n);
            if (!bus.busy && t.size() < 3) busy_low++;
            if (t.size() == 2 && n == t[1] + 5) bus.cont_mode = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        bus.cont_mode = 1'b0;
`ifdef RO_CONT_EN
        chk("cont_dones", t.size(), 3, 3);
        if (t.size() == 3) begin
            chk("cont_spacing_1", t[1] - t[0], S + 4 + 1, S + 4 + 1);
            chk("cont_spacing_2", t[2] - t[1], S + 4 + 1, S + 4 + 1);
        end
        chk("cont_busy_held", busy_low, 0, 0);
`else
        chk("cont_ignored_dones", t.size(), 1, 1);
        if (t.size() == 1) chk("cont_ignored_latency", t[0], S + 4, S + 4);
`endif
        chk("cont_end_idle", bus.busy, 0, 0);
        chk("cont_end_valid", bus.valid, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ro_meas_ctrl.md
Name: ro_meas_ctrl

Overview:
Measurement sequencer for the on-chip ring oscillator.
- On request, enables the oscillator and waits a settle time.
- Opens a gate window of programmable length in clk cycles and counts oscillator rising edges inside it.
- Disables the oscillator and publishes the count with a done/valid handshake.
- Sits between the top-level pin wrapper (start, gate length) and the oscillator's enable/output pair.

Parameters:
- CNT_W, 16: result counter width; count saturates at 2^CNT_W-1.
- GATE_W, 16: width of the gate_len input.
- SETTLE_CYCLES, 16: clk cycles the oscillator runs before the gate opens (≥1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  measurement request; sampled only in IDLE.
- gate_len  in  GATE_W  gate length in clk cycles; sampled on accepted start; 0 is treated as 1.
- cont_mode  in  1  continuous re-measure request; used only with RO_CONT_EN.
- ro_in  in  1  raw oscillator output; asynchronous to clk.
- ro_en  out  1  oscillator enable.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a result is published.
- valid  out  1  count holds a completed measurement.
- count  out  CNT_W  last published edge count.
- ovf  out  1  last published measurement saturated.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; synchronizer, gate counter and edge counter cleared. Reset mid-measurement aborts immediately and drops ro_en asynchronously.
- ro_in path: 2-flop synchronizer, then a third flop for rising-edge detect (sync2 & ~sync3). Measurable frequency is limited to below clk/2; this limit is accepted and documented.
- State IDLE:
  - start=1 → SETTLE; gate_len latched (0 becomes 1); valid, ovf and edge counter cleared.
  - start while busy is ignored and never queued.
- State SETTLE:
  - ro_en=1.
  - Counts SETTLE_CYCLES cycles, then → GATE.
  - Edge detector flops are reloaded each cycle, so no edge from settle leaks into GATE.
- State GATE:
  - ro_en=1; runs exactly latched gate_len cycles.
  - Each cycle with a detected edge increments the edge counter.
  - At all-ones the counter holds and a sticky overflow bit sets.
  - → PUBLISH after the last gate cycle.
- State PUBLISH (one cycle):
  - ro_en=0; count ← edge counter, ovf ← overflow bit, valid ← 1, done=1.
  - → IDLE, or → SETTLE per the optional feature.
- Timing: start accepted at edge k; ro_en high from k+1; GATE occupies cycles k+1+S … k+S+G, where S=SETTLE_CYCLES and G=latched gate length; done high at cycle k+1+S+G.
- Stability: count/ovf stay constant between PUBLISH cycles. valid stays high until the next accepted start.
- start high continuously restarts a new measurement on the cycle after PUBLISH. That is the first IDLE cycle, so start is accepted there.

Optional Feature:
RO_CONT_EN
- Defined: if cont_mode=1 in PUBLISH, the FSM goes directly to SETTLE instead of IDLE. gate_len is re-latched, the edge counter is cleared, busy stays 1, and valid stays 1 with the previous result until the next PUBLISH overwrites it. Deasserting cont_mode ends the sequence at the next PUBLISH.
- Undefined: cont_mode is ignored (tie-off only); PUBLISH always returns to IDLE.

Test Plan:
- Nominal: SETTLE_CYCLES=16; ro_in square wave period 8 clk; start with gate_len=64 → ro_en high 80 cycles, done one pulse 81 cycles after start accepted, count=8 (±1 for phase), valid=1, ovf=0.
- Saturation: CNT_W=4; ro_in period 4 clk; gate_len=256 → count=15, ovf=1. A following run with gate_len=16 → ovf=0, count=4±1.
- Zero gate: gate_len=0; ro_in period 4 → GATE lasts exactly 1 cycle, count ≤1, done 1+SETTLE+1 cycles after start.
- Start while busy: second start pulse during GATE → no effect on timing or count; exactly one done pulse. Changing gate_len mid-run does not alter the window.
- Reset mid-GATE: assert rst asynchronously → ro_en, busy, valid, done, count and ovf are 0 before the next clk edge. After release, start produces a correct fresh measurement.
- RO_CONT_EN: cont_mode=1 across three measurements → three done pulses, each spaced S+G+1 cycles, with busy never dropping. Clear cont_mode during the third → FSM returns to IDLE after that PUBLISH.
